// File: rtl/stopwatch_if.sv
// Control pulses in, displayed time and status out, for the millisecond stopwatch core.
// The bench drives the pulses through the master modport; the core uses the slave modport.
interface stopwatch_if;
    logic        tc_1ms;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic [27:0] disp_bcd;
    logic        running;
    logic        lap_active;
    logic        overflow;

    modport master (
        output tc_1ms, start_stop, lap, clear,
        input  disp_bcd, running, lap_active, overflow
    );

    modport slave (
        input  tc_1ms, start_stop, lap, clear,
        output disp_bcd, running, lap_active, overflow
    );
endinterface

// File: rtl/stopwatch_core.sv
// BCD stopwatch: mm:ss.mmm live counter, lap freeze register and a run/pause/lap FSM.
// Counting and every transition are decided from the pre-edge state.
module stopwatch_core #(
    parameter int MIN_LIMIT = 59
) (
    input  logic       clk,
    input  logic       reset,
    stopwatch_if.slave sw_if
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
        logic [3:0] ms2;
        logic [3:0] ms1;
        logic [3:0] ms0;
    } bcd_time_t;

    localparam logic [3:0] MIN_TENS = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] MIN_ONES = 4'(MIN_LIMIT % 10);

    state_t    r_state;
    bcd_time_t r_live;
    bcd_time_t r_lap;
    bcd_time_t r_disp;
    logic      r_running;
    logic      r_lap_active;
    logic      r_overflow;

    bcd_time_t w_live_inc;
    logic      w_count_en;
    logic      w_c_ms1;
    logic      w_c_ms2;
    logic      w_c_s0;
    logic      w_c_s1;
    logic      w_c_m;
    logic      w_wrap;

    assign w_count_en = sw_if.tc_1ms && ((r_state == S_RUN) || (r_state == S_LAP));

    // Ripple carry enables: each digit steps only when all lower digits are at their max.
    assign w_c_ms1 = (r_live.ms0 == 4'd9);
    assign w_c_ms2 = w_c_ms1 && (r_live.ms1 == 4'd9);
    assign w_c_s0  = w_c_ms2 && (r_live.ms2 == 4'd9);
    assign w_c_s1  = w_c_s0  && (r_live.s0  == 4'd9);
    assign w_c_m   = w_c_s1  && (r_live.s1  == 4'd5);
    assign w_wrap  = w_c_m   && (r_live.m1 == MIN_TENS) && (r_live.m0 == MIN_ONES);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_live_inc = r_live;
        w_live_inc.ms0 = w_c_ms1 ? 4'd0 : r_live.ms0 + 4'd1;
        if (w_c_ms1) w_live_inc.ms1 = w_c_ms2 ? 4'd0 : r_live.ms1 + 4'd1;
        if (w_c_ms2) w_live_inc.ms2 = w_c_s0  ? 4'd0 : r_live.ms2 + 4'd1;
        if (w_c_s0)  w_live_inc.s0  = w_c_s1  ? 4'd0 : r_live.s0  + 4'd1;
        if (w_c_s1)  w_live_inc.s1  = w_c_m   ? 4'd0 : r_live.s1  + 4'd1;
        if (w_c_m) begin
            if (w_wrap) begin
                w_live_inc.m1 = 4'd0;
                w_live_inc.m0 = 4'd0;
            end else if (r_live.m0 == 4'd9) begin
                w_live_inc.m1 = r_live.m1 + 4'd1;
                w_live_inc.m0 = 4'd0;
            end else begin
                w_live_inc.m0 = r_live.m0 + 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; v_next is a block-local temporary
    // written with a blocking assignment only to derive the registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        state_t v_next;
        if (!reset) begin
            // NOTE: these are plain registers, not a memory array, so all of them reset.
            r_state      <= S_IDLE;
            r_live       <= '0;
            r_lap        <= '0;
            r_disp       <= '0;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            v_next     = r_state;
            r_overflow <= 1'b0;
            r_disp     <= (r_state == S_LAP) ? r_lap : r_live;

            if (w_count_en) begin
                r_live     <= w_live_inc;
                r_overflow <= w_wrap;
            end

            // Pulses not legal in the current state are ignored, so a lower-priority pulse wins.
            case (r_state)
                S_IDLE: begin
                    if (sw_if.start_stop) v_next = S_RUN;
                end
                S_RUN: begin
                    if (sw_if.start_stop) begin
                        v_next = S_PAUSE;
                    end else if (sw_if.lap) begin
                        v_next = S_LAP;
                        r_lap  <= r_live;
                    end
                end
                S_LAP: begin
                    if (sw_if.start_stop)  v_next = S_PAUSE;
                    else if (sw_if.lap)    v_next = S_RUN;
                end
                S_PAUSE: begin
                    if (sw_if.clear) begin
                        v_next = S_IDLE;
                        r_live <= '0;
                        r_lap  <= '0;
                    end else if (sw_if.start_stop) begin
                        v_next = S_RUN;
                    end
                end
                default: v_next = S_IDLE;
            endcase

            r_state      <= v_next;
            r_running    <= (v_next == S_RUN) || (v_next == S_LAP);
            r_lap_active <= (v_next == S_LAP);
        end
    end

    assign sw_if.disp_bcd   = r_disp;
    assign sw_if.running    = r_running;
    assign sw_if.lap_active = r_lap_active;
    assign sw_if.overflow   = r_overflow;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed plus randomized bench for stopwatch_core against an elapsed-milliseconds model.
// The model keeps time as one integer and converts to BCD only for comparison.
module tb_stopwatch_core;

    localparam int MIN_LIMIT = 59;
    localparam int PERIOD    = (MIN_LIMIT + 1) * 60000;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_LAP} mstate_t;

    logic clk;
    logic reset;
    stopwatch_if sw ();

    stopwatch_core #(.MIN_LIMIT(MIN_LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .sw_if (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    mstate_t     m_state;
    int          m_ms;
    int          m_lap;
    int          m_disp;
    bit          m_ovf;
    logic [27:0] pre_val;

    function automatic logic [27:0] to_bcd(input int t);
        int m, s, ms;
        m  = t / 60000;
        s  = (t / 1000) % 60;
        ms = t % 1000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                4'(ms / 100), 4'((ms / 10) % 10), 4'(ms % 10)};
    endfunction

    task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_disp"}, sw.disp_bcd, to_bcd(m_disp));
        check({tag, "_running"}, 28'(sw.running), 28'((m_state == M_RUN) || (m_state == M_LAP)));
        check({tag, "_lap_active"}, 28'(sw.lap_active), 28'(m_state == M_LAP));
        check({tag, "_overflow"}, 28'(sw.overflow), 28'(m_ovf));
    endtask

    task automatic m_reset();
        m_state = M_IDLE;
        m_ms    = 0;
        m_lap   = 0;
        m_disp  = 0;
        m_ovf   = 0;
    endtask

    task automatic model_step(input bit t, input bit s, input bit l, input bit c);
        int      old_ms;
        mstate_t ps;
        old_ms = m_ms;
        ps     = m_state;
        m_ovf  = 0;
        m_disp = (ps == M_LAP) ? m_lap : m_ms;
        if (t && (ps == M_RUN || ps == M_LAP)) begin
            m_ms++;
            if (m_ms == PERIOD) begin
                m_ms  = 0;
                m_ovf = 1;
            end
        end
        case (ps)
            M_IDLE:  if (s) m_state = M_RUN;
            M_RUN: begin
                if (s) m_state = M_PAUSE;
                else if (l) begin
                    m_state = M_LAP;
                    m_lap   = old_ms;
                end
            end
            M_LAP: begin
                if (s) m_state = M_PAUSE;
                else if (l) m_state = M_RUN;
            end
            M_PAUSE: begin
                if (c) begin
                    m_state = M_IDLE;
                    m_ms    = 0;
                    m_lap   = 0;
                end else if (s) m_state = M_RUN;
            end
        endcase
    endtask

    // Drive one clock with the given pulses, starting and ending at a falling edge.
    task automatic cycle(input bit t, input bit s, input bit l, input bit c);
        sw.tc_1ms     = t;
        sw.start_stop = s;
        sw.lap        = l;
        sw.clear      = c;
        @(posedge clk);
        model_step(t, s, l, c);
        @(negedge clk);
        sw.tc_1ms     = 1'b0;
        sw.start_stop = 1'b0;
        sw.lap        = 1'b0;
        sw.clear      = 1'b0;
    endtask

    // Jump the live time to a chosen value between edges so carries can be reached quickly.
    task automatic preload(input int v);
        pre_val = to_bcd(v);
        force dut.r_live = pre_val;
        #1;
        release dut.r_live;
        m_ms = v;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        sw.tc_1ms     = 1'b0;
        sw.start_stop = 1'b0;
        sw.lap        = 1'b0;
        sw.clear      = 1'b0;
        reset         = 1'b0;
        m_reset();

        // Reset state, with pulses held high to show they are ignored.
        repeat (2) @(negedge clk);
        sw.tc_1ms     = 1'b1;
        sw.start_stop = 1'b1;
        @(negedge clk);
        check_all("reset");
        sw.tc_1ms     = 1'b0;
        sw.start_stop = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        check_all("post_reset");

        // Start and count 1234 ms.
        cycle(0, 1, 0, 0);
        repeat (1234) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check_all("count1234");
        check("count1234_lit", sw.disp_bcd, 28'h0001234);
        check("count1234_run", 28'(sw.running), 28'h1);

        // Pause with coincident tick at 00:00.009, then clear.
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        repeat (9) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        repeat (5) cycle(1, 0, 0, 0);
        check_all("pause_tick");
        check("pause_tick_lit", sw.disp_bcd, 28'h0000010);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        check_all("clear_idle");
        check("clear_idle_lit", sw.disp_bcd, 28'h0000000);
        cycle(0, 1, 0, 0);
        repeat (3) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 0);
        check_all("clear_in_run");
        check("clear_in_run_lit", sw.disp_bcd, 28'h0000004);

        // Lap at 00:00.500 with a coincident tick that must not be captured.
        preload(500);
        cycle(1, 0, 1, 0);
        repeat (299) cycle(1, 0, 0, 0);
        check_all("lap_hold");
        check("lap_hold_lit", sw.disp_bcd, 28'h0000500);
        check("lap_hold_active", 28'(sw.lap_active), 28'h1);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        check_all("lap_release");
        check("lap_release_lit", sw.disp_bcd, 28'h0000800);

        // Seconds-to-minutes carry and full wrap.
        preload(59999);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check_all("min_carry");
        check("min_carry_lit", sw.disp_bcd, 28'h0100000);
        preload(PERIOD - 1);
        cycle(1, 0, 0, 0);
        check_all("wrap_edge");
        check("wrap_ovf_hi", 28'(sw.overflow), 28'h1);
        cycle(0, 0, 0, 0);
        check_all("wrap_after");
        check("wrap_ovf_lo", 28'(sw.overflow), 28'h0);
        check("wrap_lit", sw.disp_bcd, 28'h0000000);

        // Simultaneous pulses.
        repeat (7) cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 1);
        cycle(0, 0, 0, 0);
        check_all("clr_and_ss");
        check("clr_and_ss_lit", sw.disp_bcd, 28'h0000000);
        check("clr_and_ss_run", 28'(sw.running), 28'h0);
        cycle(0, 1, 0, 0);
        repeat (4) cycle(1, 0, 0, 0);
        cycle(0, 1, 1, 0);
        check_all("ss_and_lap");
        check("ss_and_lap_lact", 28'(sw.lap_active), 28'h0);

        // Randomized pulses, ticks and boundary preloads against the model.
        for (int i = 0; i < 600; i++) begin
            if ((i % 64) == 10) begin
                case ($urandom_range(0, 2))
                    0:       preload(996);
                    1:       preload(59997);
                    default: preload(PERIOD - 3);
                endcase
            end
            cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            check_all("rand");
        end

        // Reset asserted between edges mid-run.
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        repeat (25) cycle(1, 0, 0, 0);
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        check_all("async_reset");
        sw.tc_1ms     = 1'b1;
        sw.start_stop = 1'b1;
        sw.lap        = 1'b1;
        @(negedge clk);
        check_all("reset_held");
        sw.tc_1ms     = 1'b0;
        sw.start_stop = 1'b0;
        sw.lap        = 1'b0;
        reset         = 1'b1;
        repeat (20) cycle(1, 0, 0, 0);
        check_all("idle_after_reset");
        check("idle_after_reset_lit", sw.disp_bcd, 28'h0000000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
